mem_stream_reader: RTL

- Read-side engine for the team's simple dual-port (1R1W) synchronous memory, which has a 1-cycle registered read.
- On a start command it walks the read port from a base address for a given word count. It streams the words out on a valid/ready interface at up to one word per cycle.
- It absorbs the memory read latency and downstream backpressure with a 2-entry buffer.
- It sits between the memory's read port and any consumer. The write port is owned elsewhere.

---
 rtl/mem_stream_pkg.sv | 20 ++
 rtl/mem_stream_skid_buf.sv | 74 +++++++
 rtl/mem_stream_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory stream reader.
//   state_t   : command FSM states (IDLE, RUN, DRAIN)
//   BUF_DEPTH : entries in the output skid buffer
//   OCC_W     : width of the buffer occupancy count (0..BUF_DEPTH)
package mem_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = 2;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/mem_stream_skid_buf.sv
// Two-entry registered FIFO that absorbs the memory read latency and
// consumer backpressure. Push and pop in the same cycle are both honoured.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe and data (ignored when full and not popping)
//   pop        : remove head entry (ignored when empty)
//   occ        : current occupancy 0..2
//   head       : oldest entry, straight from a register
module mem_stream_skid_buf
  import mem_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [OCC_W-1:0]      occ_r;
  logic                  pop_ok_s;
  logic                  push_ok_s;

  // Qualify push/pop against the current fill level.
  always_comb begin
    pop_ok_s  = pop && (occ_r != OCC_EMPTY);
    push_ok_s = push && ((occ_r != OCC_FULL) || pop_ok_s);
  end

  // Entry storage and occupancy; head always holds the oldest word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= {DATA_WIDTH{1'b0}};
      tail_r <= {DATA_WIDTH{1'b0}};
      occ_r  <= OCC_EMPTY;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (occ_r == OCC_EMPTY) begin
            head_r <= din;
          end else begin
            tail_r <= din;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          head_r <= tail_r;
          occ_r  <= occ_r - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (occ_r == OCC_ONE) begin
            head_r <= din;
          end else begin
            head_r <= tail_r;
            tail_r <= din;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  assign occ  = occ_r;
  assign head = head_r;

endmodule

// File: rtl/mem_stream_reader.sv
// Read-side engine for a 1R1W synchronous memory with a 1-cycle registered
// read. A start command walks the read port from base for len words and
// streams them out on a valid/ready interface at up to one word per cycle.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, base, len: command strobe (sampled in IDLE), first address, count
//   busy, done      : command active; 1-cycle completion pulse
//   ra, rd          : memory read address / read data (valid 1 cycle later)
//   out_valid, out_ready, out_data : output stream
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ra,
  input  logic [DATA_WIDTH-1:0] rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r;
  state_t                state_n;
  logic                  busy_r;
  logic                  done_r;
  logic                  done_n;
  logic                  inflight_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] ra_hold_r;
  logic [ADDR_WIDTH:0]   issue_cnt_r;
  logic [ADDR_WIDTH:0]   beat_cnt_r;
  logic [OCC_W-1:0]      occ_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic                  room_s;
  logic                  beat_s;
  logic                  issue_s;
  logic                  load_s;

  mem_stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (inflight_r),
    .din  (rd),
    .pop  (beat_s),
    .occ  (occ_s),
    .head (head_s)
  );

  // Issue decision: a read may go out when buffer plus in-flight word leave
  // room, or when a beat frees a slot this cycle (out_ready reaches ra here).
  always_comb begin
    room_s  = (occ_s == OCC_EMPTY) || ((occ_s == OCC_ONE) && !inflight_r);
    beat_s  = (occ_s != OCC_EMPTY) && out_ready;
    issue_s = (state_r == ST_RUN) && (room_s || beat_s);
    load_s  = (state_r == ST_IDLE) && start && (len != CNT_ZERO);
  end

  // Next-state and completion-pulse logic.
  always_comb begin
    state_n = state_r;
    done_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (len != CNT_ZERO) begin
            state_n = ST_RUN;
          end else begin
            done_n = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s && (issue_cnt_r == CNT_ONE)) begin
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (beat_s && (beat_cnt_r == CNT_ONE)) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Command state, address walk and word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      inflight_r  <= 1'b0;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      ra_hold_r   <= {ADDR_WIDTH{1'b0}};
      issue_cnt_r <= CNT_ZERO;
      beat_cnt_r  <= CNT_ZERO;
    end else begin
      state_r    <= state_n;
      busy_r     <= (state_n != ST_IDLE);
      done_r     <= done_n;
      inflight_r <= issue_s;
      if (load_s) begin
        addr_r      <= base;
        issue_cnt_r <= len;
        beat_cnt_r  <= len;
      end else begin
        if (issue_s) begin
          addr_r      <= addr_r + ADDR_ONE;
          issue_cnt_r <= issue_cnt_r - CNT_ONE;
          ra_hold_r   <= addr_r;
        end else begin
          ra_hold_r <= ra_hold_r;
        end
        if (beat_s) begin
          beat_cnt_r <= beat_cnt_r - CNT_ONE;
        end else begin
          beat_cnt_r <= beat_cnt_r;
        end
      end
    end
  end

  assign ra        = issue_s ? addr_r : ra_hold_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign out_valid = (occ_s != OCC_EMPTY);
  assign out_data  = head_s;

endmodule
